rf_hazard_ctl: RTL
==================

// Module: rf_hazard_ctl
// PURPOSE
//  Hazard scheduler for the register-fetch stage; sits beside rf_stage and drives its forwarding selects.
//  Tracks destination registers of the instructions in EX and MEM.
//  Produces the rs/rt forward selects for the RF-stage fwd_mux pair.
//  Detects load-use hazards and inserts one EX bubble while freezing the RF/IF latches.
// PARAMETERS
//  REG_AW     5   register index width
//  CNT_W      16  width of the saturating stall-cycle counter
// PORTS
//  clk           in   1      pipeline clock
//  rst_i         in   1      asynchronous reset, active-low
//  pause         in   1      global pipeline freeze; all state holds
//  rs_n_i        in   5      rs index of instruction in RF
//  rt_n_i        in   5      rt index of instruction in RF
//  rs_used_i     in   1      RF instruction reads rs
//  rt_used_i     in   1      RF instruction reads rt
//  rd_index_i    in   5      destination of RF instruction (after rd_sel)
//  rd_we_i       in   1      RF instruction writes rd_index_i
//  is_load_i     in   1      RF instruction is a load
//  fw_cmp_rs     out  3      rs forward select
//  fw_cmp_rt     out  3      rt forward select
//  stall_o       out  1      hold PC, IF/RF instruction register (cls)
//  ex_bubble_o   out  1      clear RA->EX control latch (bubble)
//  stall_cnt_o   out  CNT_W  total load-use stall cycles, saturating
// BEHAVIOUR
//  State: ex_rd/ex_we/ex_ld and mem_rd/mem_we, plus FSM {RUN, STALL}.
//  Reset (rst_i=0, async): ex_*/mem_* = 0, FSM=RUN, stall_cnt_o=0.
//   Outputs then: fw_cmp_*=FW_RF, stall_o=0, ex_bubble_o=0.
//  Match rule: src used AND index!=0 AND index==stage rd AND stage we.
//  Forward select (combinational, same cycle), per source:
//   EX match & !ex_ld -> FW_ALU; else MEM match -> FW_MEM; else FW_RF.
//   EX wins over MEM when both match (youngest producer).
//  Load-use: EX match with ex_ld=1 in RUN -> hazard.
//   hazard: stall_o=1, ex_bubble_o=1 same cycle; that source selects FW_RF (don't-care).
//  Pipeline shift on every clk edge with pause=0:
//   mem_* <= ex_* (mem_we <= ex_we).
//   ex_* <= RF fields, or zeros when hazard (bubble).
//  FSM RUN --hazard & !pause--> STALL.
//   STALL lasts exactly one cycle: stall_o=0, load now in MEM, FW_MEM selected.
//   STALL -> RUN unconditionally on next unpaused edge.
//   A new hazard cannot arise in STALL: EX holds a bubble.
//  pause=1: no state update, counter holds.
//   Outputs still recomputed combinationally from held state.
//  stall_cnt_o: +1 per unpaused edge with hazard; saturates at all-ones, no wrap.
//  rs==rt both matching: both selects set identically; one stall only.
//  Reset asserted during STALL: returns to RUN, bubble lost, no pending stall.
//  rd_we_i with rd_index_i=0: recorded but never matches (r0 hardwired).
// STRUCTURE
//  mips789_defs.v gains:
//   `FW_RF=3'd0, `FW_ALU=3'd1, `FW_MEM=3'd2
//   FSM encodings `HZ_RUN=1'b0, `HZ_STALL=1'b1
//  Sub-module fw_sel:
//   combinational match/priority for one source; instantiated twice (rs, rt).
//  Top holds scoreboard regs, FSM, counter.
// TESTING
//  1 reset: rst_i=0 mid-run -> fw_cmp_*=0, stall_o=0, stall_cnt_o=0 immediately.
//  2 ALU fwd: add r3 then use rs=3 next cycle -> fw_cmp_rs=1;
//    one cycle later, if still used -> fw_cmp_rs=2.
//  3 load-use: lw r5 then rt=5 used -> stall_o=1, ex_bubble_o=1 one cycle;
//    next cycle fw_cmp_rt=2, stall_cnt_o=1.
//  4 r0: producer rd=0 rd_we=1, consumer rs=0 -> fw_cmp_rs=0, no stall.
//  5 priority: r7 written in EX and MEM, rs=7 -> fw_cmp_rs=1 (EX).
//  6 pause: hazard with pause=1 for 3 cycles -> stall_o stays 1, counter unchanged;
//    release -> exactly one stall counted, then FW_MEM.

Source files
------------

// File: rtl/rf_hazard_ctl_pkg.sv
// Shared constants and types for the register-fetch hazard scheduler:
// forward-select encodings, FSM state type and default widths.
package rf_hazard_ctl_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 16;
    localparam int FW_W       = 3;

    localparam logic [FW_W-1:0] FW_RF  = 3'd0;
    localparam logic [FW_W-1:0] FW_ALU = 3'd1;
    localparam logic [FW_W-1:0] FW_MEM = 3'd2;

    typedef enum logic {
        HZ_RUN   = 1'b0,
        HZ_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/rf_hazard_ctl_if.sv
// RF-stage <-> hazard scheduler bundle: decoded RF operand/destination
// fields towards the scheduler, forward selects and stall controls back.
interface rf_hazard_ctl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] rs_n_i;
    logic [REG_AW-1:0] rt_n_i;
    logic              rs_used_i;
    logic              rt_used_i;
    logic [REG_AW-1:0] rd_index_i;
    logic              rd_we_i;
    logic              is_load_i;
    logic [2:0]        fw_cmp_rs;
    logic [2:0]        fw_cmp_rt;
    logic              stall_o;
    logic              ex_bubble_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output rs_n_i, rt_n_i, rs_used_i, rt_used_i,
               rd_index_i, rd_we_i, is_load_i,
        input  fw_cmp_rs, fw_cmp_rt, stall_o, ex_bubble_o, stall_cnt_o
    );

    modport slave (
        input  rs_n_i, rt_n_i, rs_used_i, rt_used_i,
               rd_index_i, rd_we_i, is_load_i,
        output fw_cmp_rs, fw_cmp_rt, stall_o, ex_bubble_o, stall_cnt_o
    );
endinterface

// File: rtl/rf_hazard_ctl_fw_sel.sv
// Forward-select decision for one source operand against the EX and MEM
// producers; also flags a load in EX that this source depends on.
module rf_hazard_ctl_fw_sel
    import rf_hazard_ctl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              src_used,
    input  logic [REG_AW-1:0] src_idx,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_we,
    input  logic              ex_ld,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_we,
    output logic [FW_W-1:0]   fw_sel_s,
    output logic              ld_hit_s
);

    // r0 is hardwired, so a recorded write to index 0 never produces a match.
    function automatic logic stage_match(
        input logic              used,
        input logic [REG_AW-1:0] idx,
        input logic [REG_AW-1:0] rd,
        input logic              we
    );
        return used && (idx != {REG_AW{1'b0}}) && (idx == rd) && we;
    endfunction

    logic ex_hit_s;
    logic mem_hit_s;

    // Match both stages, youngest producer (EX) wins over MEM.
    always_comb begin
        ex_hit_s  = stage_match(src_used, src_idx, ex_rd, ex_we);
        mem_hit_s = stage_match(src_used, src_idx, mem_rd, mem_we);
        fw_sel_s  = FW_RF;
        ld_hit_s  = 1'b0;
        if (ex_hit_s && !ex_ld) begin
            fw_sel_s = FW_ALU;
        end else if (ex_hit_s) begin
            // Load result not yet available: the stall makes this select moot.
            fw_sel_s = FW_RF;
            ld_hit_s = 1'b1;
        end else if (mem_hit_s) begin
            fw_sel_s = FW_MEM;
        end else begin
            fw_sel_s = FW_RF;
        end
    end

endmodule

// File: rtl/rf_hazard_ctl.sv
// Register-fetch hazard scheduler: tracks EX/MEM destinations, drives the
// rs/rt forward selects and inserts a single bubble on a load-use hazard.
module rf_hazard_ctl
    import rf_hazard_ctl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst_i,
    input  logic           pause,
    rf_hazard_ctl_if.slave hz
);

    logic [REG_AW-1:0] ex_rd_r;
    logic              ex_we_r;
    logic              ex_ld_r;
    logic [REG_AW-1:0] mem_rd_r;
    logic              mem_we_r;
    hz_state_t         state_r;
    hz_state_t         state_s;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [FW_W-1:0]   rs_sel_s;
    logic [FW_W-1:0]   rt_sel_s;
    logic              rs_ld_hit_s;
    logic              rt_ld_hit_s;
    logic              hazard_s;

    rf_hazard_ctl_fw_sel #(.REG_AW(REG_AW)) u_fw_rs (
        .src_used (hz.rs_used_i),
        .src_idx  (hz.rs_n_i),
        .ex_rd    (ex_rd_r),
        .ex_we    (ex_we_r),
        .ex_ld    (ex_ld_r),
        .mem_rd   (mem_rd_r),
        .mem_we   (mem_we_r),
        .fw_sel_s (rs_sel_s),
        .ld_hit_s (rs_ld_hit_s)
    );

    rf_hazard_ctl_fw_sel #(.REG_AW(REG_AW)) u_fw_rt (
        .src_used (hz.rt_used_i),
        .src_idx  (hz.rt_n_i),
        .ex_rd    (ex_rd_r),
        .ex_we    (ex_we_r),
        .ex_ld    (ex_ld_r),
        .mem_rd   (mem_rd_r),
        .mem_we   (mem_we_r),
        .fw_sel_s (rt_sel_s),
        .ld_hit_s (rt_ld_hit_s)
    );

    // Next-state and hazard decode; a shared rs/rt hit still yields one stall.
    always_comb begin
        hazard_s = 1'b0;
        state_s  = state_r;
        case (state_r)
            HZ_RUN: begin
                hazard_s = rs_ld_hit_s || rt_ld_hit_s;
                if (hazard_s) begin
                    state_s = HZ_STALL;
                end else begin
                    state_s = HZ_RUN;
                end
            end
            HZ_STALL: begin
                // EX holds the bubble here, so no new hazard is possible.
                hazard_s = 1'b0;
                state_s  = HZ_RUN;
            end
            default: begin
                hazard_s = 1'b0;
                state_s  = HZ_RUN;
            end
        endcase
    end

    // FSM state register; pause freezes it.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= HZ_RUN;
        end else if (!pause) begin
            state_r <= state_s;
        end
    end

    // EX/MEM destination scoreboard; a hazard loads a bubble into EX.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            ex_rd_r  <= {REG_AW{1'b0}};
            ex_we_r  <= 1'b0;
            ex_ld_r  <= 1'b0;
            mem_rd_r <= {REG_AW{1'b0}};
            mem_we_r <= 1'b0;
        end else if (!pause) begin
            mem_rd_r <= ex_rd_r;
            mem_we_r <= ex_we_r;
            if (hazard_s) begin
                ex_rd_r <= {REG_AW{1'b0}};
                ex_we_r <= 1'b0;
                ex_ld_r <= 1'b0;
            end else begin
                ex_rd_r <= hz.rd_index_i;
                ex_we_r <= hz.rd_we_i;
                ex_ld_r <= hz.is_load_i;
            end
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!pause && hazard_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
        end
    end

    assign hz.fw_cmp_rs   = rs_sel_s;
    assign hz.fw_cmp_rt   = rt_sel_s;
    assign hz.stall_o     = hazard_s;
    assign hz.ex_bubble_o = hazard_s;
    assign hz.stall_cnt_o = stall_cnt_r;

endmodule
